// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t      : controller FSM states (RUN=0, MEM_WAIT=1, FAULT=2)
//   REG_ZERO     : architectural $zero register index
//   ctrl_word_t  : pipeline-register control word; BUBBLE_CTRL is the all-zero
//                  word loaded by every flushed pipeline register
//   load_use_hit : load-use hazard detection between EX and ID
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t BUBBLE_CTRL = '0;

    // A load in EX whose destination feeds an ID source operand. $zero is
    // never a real dependency because it is hard-wired to zero.
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush statistics.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one event this cycle
//   count    : current value, sticks at all ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   Inputs : ID source fields (idRs, idRt, idUsesRt), load in EX (exMemRead,
//            exRt), branch/zero and memory flags held in EX/MEM, dmemReady.
//   Outputs: dmemReq, register load enables (pcWrite, ifidWrite, idexWrite,
//            exmemWrite), bubble controls (ifidFlush, idexFlush, exmemFlush,
//            memwbFlush), pcSrc, sticky memTimeout, and saturating
//            stallCycles / flushCount statistics.
// Control outputs are combinational from state and inputs; state, the memory
// wait counter and the statistics are registered.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             memBranch,
    input  logic             memZero,
    input  logic             memMemRead,
    input  logic             memMemWrite,
    input  logic             dmemReady,
    output logic             dmemReq,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexWrite,
    output logic             exmemWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             exmemFlush,
    output logic             memwbFlush,
    output logic             pcSrc,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              load_use;
    logic              taken;
    logic              mem_access;
    logic              resolve;

    assign load_use   = load_use_hit(exMemRead, exRt, idRs, idRt, idUsesRt);
    assign taken      = memBranch & memZero;
    assign mem_access = memMemRead | memMemWrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        wait_next  = wait_cnt;
        resolve    = 1'b0;
        dmemReq    = 1'b0;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        exmemWrite = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        memwbFlush = 1'b0;
        pcSrc      = 1'b0;
        memTimeout = 1'b0;

        unique case (state)
            RUN: begin
                wait_next = '0;
                dmemReq   = mem_access;
                if (mem_access && !dmemReady) begin
                    // Freeze everything up to EX/MEM; MEM/WB takes a bubble
                    // because the access has not produced a result yet.
                    {pcWrite, ifidWrite, idexWrite, exmemWrite} = 4'b0000;
                    memwbFlush = 1'b1;
                    next_state = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmemReq = 1'b1;
                if (!dmemReady) begin
                    {pcWrite, ifidWrite, idexWrite, exmemWrite} = 4'b0000;
                    memwbFlush = 1'b1;
                    if (wait_cnt == WAIT_MAX) begin
                        next_state = FAULT;
                    end else begin
                        wait_next = wait_cnt + 1'b1;
                    end
                end else begin
                    // Release in the completing cycle; hazards that piled up
                    // behind the access are resolved right away.
                    next_state = RUN;
                    wait_next  = '0;
                    resolve    = 1'b1;
                end
            end
            FAULT: begin
                {pcWrite, ifidWrite, idexWrite, exmemWrite} = 4'b0000;
                memwbFlush = 1'b1;
                memTimeout = 1'b1;
            end
            default: begin
                next_state = RUN;
                wait_next  = '0;
            end
        endcase

        // Taken branch squashes IF/ID, ID/EX and EX/MEM, which also removes
        // any load-use consumer, so it takes priority.
        if (resolve) begin
            if (taken) begin
                pcSrc      = 1'b1;
                ifidFlush  = 1'b1;
                idexFlush  = 1'b1;
                exmemFlush = 1'b1;
            end else if (load_use) begin
                pcWrite   = 1'b0;
                ifidWrite = 1'b0;
                idexFlush = 1'b1;
            end
        end

        if (rst) begin
            dmemReq    = 1'b0;
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            ifidFlush  = 1'b0;
            idexFlush  = 1'b0;
            exmemFlush = 1'b0;
            memwbFlush = 1'b0;
            pcSrc      = 1'b0;
            memTimeout = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (!pcWrite),
        .count (stallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (pcSrc),
        .count (flushCount)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. Uses MEM_TIMEOUT=4 and a
// 4-bit statistics width so the timeout and counter saturation are reachable.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       idRs, idRt, exRt;
    logic             idUsesRt, exMemRead, memBranch, memZero;
    logic             memMemRead, memMemWrite, dmemReady;
    logic             dmemReq, pcWrite, ifidWrite, idexWrite, exmemWrite;
    logic             ifidFlush, idexFlush, exmemFlush, memwbFlush;
    logic             pcSrc, memTimeout;
    logic [CNT_W-1:0] stallCycles, flushCount;
    logic [10:0]      ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    // {dmemReq, pcW, ifidW, idexW, exmemW, ifidF, idexF, exmemF, memwbF, pcSrc, memTimeout}
    localparam logic [10:0] C_RST    = 11'b0_0000_0000_0_0;
    localparam logic [10:0] C_IDLE   = 11'b0_1111_0000_0_0;
    localparam logic [10:0] C_LU     = 11'b0_0011_0100_0_0;
    localparam logic [10:0] C_BR     = 11'b0_1111_1110_1_0;
    localparam logic [10:0] C_MSTALL = 11'b1_0000_0001_0_0;
    localparam logic [10:0] C_MGO    = 11'b1_1111_0000_0_0;
    localparam logic [10:0] C_FAULT  = 11'b0_0000_0001_0_1;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .idRs        (idRs),
        .idRt        (idRt),
        .idUsesRt    (idUsesRt),
        .exMemRead   (exMemRead),
        .exRt        (exRt),
        .memBranch   (memBranch),
        .memZero     (memZero),
        .memMemRead  (memMemRead),
        .memMemWrite (memMemWrite),
        .dmemReady   (dmemReady),
        .dmemReq     (dmemReq),
        .pcWrite     (pcWrite),
        .ifidWrite   (ifidWrite),
        .idexWrite   (idexWrite),
        .exmemWrite  (exmemWrite),
        .ifidFlush   (ifidFlush),
        .idexFlush   (idexFlush),
        .exmemFlush  (exmemFlush),
        .memwbFlush  (memwbFlush),
        .pcSrc       (pcSrc),
        .memTimeout  (memTimeout),
        .stallCycles (stallCycles),
        .flushCount  (flushCount)
    );

    assign ctrl = {dmemReq, pcWrite, ifidWrite, idexWrite, exmemWrite,
                   ifidFlush, idexFlush, exmemFlush, memwbFlush, pcSrc, memTimeout};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b0;
        exMemRead = 1'b0; exRt = 5'd0;
        memBranch = 1'b0; memZero = 1'b0;
        memMemRead = 1'b0; memMemWrite = 1'b0; dmemReady = 1'b1;
    endtask

    // Check the combinational controls mid-cycle, then advance past the edge.
    task automatic cycle_ctrl(input string tag, input logic [10:0] expected);
        @(negedge clk);
        check(tag, 32'(ctrl), 32'(expected));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        check("reset_ctrl", 32'(ctrl), 32'(C_RST));
        check("reset_stall", 32'(stallCycles), 32'd0);
        check("reset_flush", 32'(flushCount), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cycle_ctrl("idle", C_IDLE);

        // Load-use on rs
        exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8;
        cycle_ctrl("lu_rs", C_LU);
        check("lu_rs_stall", 32'(stallCycles), 32'd1);
        idle_inputs();
        cycle_ctrl("lu_bubble", C_IDLE);

        // Load-use on rt, only when rt is a source
        exMemRead = 1'b1; exRt = 5'd9; idRt = 5'd9; idRs = 5'd3; idUsesRt = 1'b1;
        cycle_ctrl("lu_rt", C_LU);
        check("lu_rt_stall", 32'(stallCycles), 32'd2);
        idUsesRt = 1'b0;
        cycle_ctrl("lu_rt_unused", C_IDLE);

        // Load to $zero never stalls
        idle_inputs();
        exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0;
        cycle_ctrl("lu_zero", C_IDLE);
        check("lu_zero_stall", 32'(stallCycles), 32'd2);

        // Branch taken / not taken
        idle_inputs();
        memBranch = 1'b1; memZero = 1'b1;
        cycle_ctrl("br_taken", C_BR);
        check("br_flush_cnt", 32'(flushCount), 32'd1);
        memZero = 1'b0;
        cycle_ctrl("br_not_taken", C_IDLE);
        check("br_nt_flush_cnt", 32'(flushCount), 32'd1);

        // Branch and load-use together: branch wins, no stall counted
        memZero = 1'b1; exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8;
        cycle_ctrl("br_vs_lu", C_BR);
        check("br_vs_lu_stall", 32'(stallCycles), 32'd2);
        check("br_vs_lu_flush", 32'(flushCount), 32'd2);

        // Store completing immediately: request, no stall
        idle_inputs();
        memMemWrite = 1'b1; dmemReady = 1'b1;
        cycle_ctrl("store_ready", C_MGO);

        // Three wait cycles, release on the fourth
        idle_inputs();
        memMemRead = 1'b1; dmemReady = 1'b0;
        for (int i = 0; i < 3; i++) cycle_ctrl($sformatf("mwait_%0d", i), C_MSTALL);
        check("mwait_stall", 32'(stallCycles), 32'd5);
        dmemReady = 1'b1;
        cycle_ctrl("mwait_release", C_MGO);
        check("mwait_release_stall", 32'(stallCycles), 32'd5);
        idle_inputs();
        cycle_ctrl("mwait_back_run", C_IDLE);

        // Timeout: wait counter reaches MEM_TIMEOUT=4 after the 5th stalled cycle
        memMemRead = 1'b1; dmemReady = 1'b0;
        for (int i = 0; i < 5; i++) cycle_ctrl($sformatf("tmo_wait_%0d", i), C_MSTALL);
        check("tmo_stall", 32'(stallCycles), 32'd10);
        cycle_ctrl("fault", C_FAULT);
        check("fault_stall", 32'(stallCycles), 32'd11);
        idle_inputs();
        cycle_ctrl("fault_sticky", C_FAULT);
        for (int i = 0; i < 5; i++) cycle_ctrl($sformatf("fault_hold_%0d", i), C_FAULT);
        check("stall_saturated", 32'(stallCycles), 32'd15);

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", 32'(ctrl), 32'(C_RST));
        check("async_rst_stall", 32'(stallCycles), 32'd0);
        check("async_rst_flush", 32'(flushCount), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle_ctrl("after_rst_run", C_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. Watches the ID stage, the ID/EX and EX/MEM pipeline registers and the data-memory handshake. Drives the write enables and flush (bubble) controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves load-use hazards, taken branches committed from EX/MEM, and multi-cycle data-memory accesses, and keeps saturating stall/flush statistics.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles on a data-memory access before fault.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- idRs  in  5  rs field of the instruction in ID.
- idRt  in  5  rt field of the instruction in ID.
- idUsesRt  in  1  ID instruction reads rt as a source.
- exMemRead  in  1  memRead held in ID/EX.
- exRt  in  5  destination register of the instruction in EX.
- memBranch  in  1  branch flag held in EX/MEM.
- memZero  in  1  zero flag held in EX/MEM.
- memMemRead, memMemWrite  in  1 each  memRead/memWrite held in EX/MEM.
- dmemReady  in  1  data memory completes the current access this cycle.
- dmemReq  out  1  data-memory access request.
- pcWrite, ifidWrite, idexWrite, exmemWrite  out  1 each  register load enables.
- ifidFlush, idexFlush, exmemFlush, memwbFlush  out  1 each  load a bubble (all control bits 0) at the next edge.
- pcSrc  out  1  select branch target from EX/MEM.
- memTimeout  out  1  sticky fault flag.
- stallCycles  out  CNT_W  cycles with pcWrite=0, saturating.
- flushCount  out  CNT_W  taken branches, saturating.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT.
- Control outputs are combinational from state and inputs. State, wait counter and statistics are registered.
- Defaults: all write enables 1, all flushes 0, pcSrc 0, dmemReq 0.
- RUN, priority high to low:
  - Memory access: memMemRead|memMemWrite gives dmemReq=1.
    - If dmemReady=0: pcWrite, ifidWrite, idexWrite and exmemWrite all 0, memwbFlush=1. Next state MEM_WAIT, wait counter reset to 1.
    - If dmemReady=1: no stall.
  - Taken branch: memBranch&memZero gives pcSrc=1 and ifidFlush=idexFlush=exmemFlush=1. flushCount increments. Overrides load-use.
  - Load-use: exMemRead && exRt!=0 && (exRt==idRs || (idUsesRt && exRt==idRt)) gives pcWrite=0, ifidWrite=0, idexFlush=1 for exactly one cycle.
- MEM_WAIT:
  - dmemReq=1, same freeze and memwbFlush as above, while dmemReady=0. Wait counter increments.
  - On dmemReady=1, stalls release in the same cycle and the state returns to RUN. A pending load-use or taken branch is then evaluated as in RUN.
  - If dmemReady=0 and the wait counter equals MEM_TIMEOUT, next state is FAULT.
- FAULT:
  - All write enables 0, memwbFlush=1, dmemReq=0, memTimeout=1.
  - Only rst leaves FAULT.
- Counters saturate at all ones and never wrap.

## Timing
- Reset, while rst=1:
  - State RUN, wait counter 0, stallCycles=0, flushCount=0, memTimeout=0.
  - Combinational outputs forced to: all enables 0, all flushes 0, dmemReq 0, pcSrc 0.
- Deassertion: normal operation from the first posedge after rst falls.
- Latency:
  - Stall and flush decisions take effect at the same-cycle posedge (zero-cycle decode).
  - Statistics update at that edge.
- Load-use costs exactly 1 bubble.
- Taken branch costs 3 squashed instructions.
- Memory wait costs N stall cycles for N cycles of dmemReady=0.
- rst asserted mid-MEM_WAIT or in FAULT returns to RUN immediately (asynchronous) and clears memTimeout.

## Structure
- Shared package holds:
  - the FSM state typedef (RUN=0, MEM_WAIT=1, FAULT=2);
  - the constant REG_ZERO=5'd0;
  - the bubble control-word constant used by all pipeline registers.
- One sub-module: sat_counter (parameterized width, inc, synchronous clear, async rst), instantiated twice for the statistics.

## Test plan
- Load-use: lw to $t0 in EX (exMemRead=1, exRt=8), ID add with idRs=8 → for one cycle pcWrite=0, ifidWrite=0, idexFlush=1; stallCycles goes 0→1.
- Load to $zero: exRt=0, idRs=0 → no stall, all enables 1.
- Taken branch: memBranch=1, memZero=1 → pcSrc=1, ifid/idex/exmem flush=1 in that cycle; flushCount=1. With memZero=0 → no flush.
- Memory wait: memMemRead=1, dmemReady low for 3 cycles then high → 3 cycles of enables=0 and memwbFlush=1, release on the 4th cycle; stallCycles=3.
- Timeout: MEM_TIMEOUT=4, dmemReady held 0 → FAULT entered after 4 wait cycles, memTimeout=1 sticky. Asynchronous rst then clears memTimeout to 0 and returns the FSM to RUN without a clock edge.
- Simultaneous: taken branch and load-use match in the same cycle → branch wins: pcWrite=1, pcSrc=1, flushes asserted, stallCycles unchanged.
